fcl_cfg_loader: RTL and testbench

//   Responder side of the field-config-load (FCL) handshake. Accepts a one-cycle
//   go strobe plus a load_cfg_req_t request from the FCL controller, then writes
//   the requested start pattern into the field memory, one row per cycle.

---
 rtl/fcl_cfg_loader.sv | 118 +++++++++++
 tb/tb_fcl_cfg_loader.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fcl_cfg_loader.sv
// FCL responder: on go+CFG_1, writes the requested start pattern into field memory, one row per cycle.
// Optional write back-pressure (i_wr_ready) is enabled by defining FCL_LOADER_WR_READY_EN.
package defs;
    typedef enum logic [1:0] {
        NO_REQ = 2'd0,
        CFG_1  = 2'd1
    } load_cfg_req_t;
endpackage

module fcl_cfg_loader #(
    parameter int FIELD_W = 32,
    parameter int FIELD_H = 32,
    localparam int ADDR_W = (FIELD_H > 1) ? $clog2(FIELD_H) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_go,
    input  defs::load_cfg_req_t i_cfg_req,
    output logic                o_is_loading,
    output logic                o_wr_en,
    output logic [ADDR_W-1:0]   o_wr_addr,
    output logic [FIELD_W-1:0]  o_wr_data
`ifdef FCL_LOADER_WR_READY_EN
    ,
    input  logic                i_wr_ready
`endif
);

    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(FIELD_H - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOAD = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_row;
    logic [ADDR_W-1:0]   w_row_nxt;
    defs::load_cfg_req_t r_cfg;
    defs::load_cfg_req_t w_cfg_nxt;
    logic                w_ready;
    logic                w_wr_accept;
    logic [FIELD_W-1:0]  w_pattern;

    // Write handshake: a row is committed on a cycle where o_wr_en && ready;
    // while ready is low the row's address and data are held unchanged.
`ifdef FCL_LOADER_WR_READY_EN
    assign w_ready = i_wr_ready;
`else
    assign w_ready = 1'b1;
`endif

    assign w_wr_accept = (r_state == ST_LOAD) && w_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_row   <= '0;
            r_cfg   <= defs::NO_REQ;
        end else begin
            r_state <= w_state_nxt;
            r_row   <= w_row_nxt;
            r_cfg   <= w_cfg_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_cfg_nxt   = r_cfg;
        case (r_state)
            ST_IDLE: begin
                if (i_go && (i_cfg_req == defs::CFG_1)) begin
                    w_state_nxt = ST_LOAD;
                    w_row_nxt   = '0;
                    w_cfg_nxt   = i_cfg_req;
                end
            end
            ST_LOAD: begin
                // i_go and i_cfg_req are deliberately not looked at here.
                if (w_wr_accept) begin
                    if (r_row == LAST_ROW) begin
                        w_state_nxt = ST_IDLE;
                        w_row_nxt   = '0;
                    end else begin
                        w_row_nxt = r_row + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_row_nxt   = '0;
            end
        endcase
    end

    // Glider in the top-left corner; bit c is column c.
    always_comb begin
        w_pattern = '0;
        if (r_cfg == defs::CFG_1) begin
            case (r_row)
                ADDR_W'(0): w_pattern[1]   = 1'b1;
                ADDR_W'(1): w_pattern[2]   = 1'b1;
                ADDR_W'(2): w_pattern[2:0] = 3'b111;
                default:    w_pattern      = '0;
            endcase
        end
    end

    always_comb begin
        o_is_loading = (r_state == ST_LOAD);
        o_wr_en      = (r_state == ST_LOAD);
        o_wr_addr    = (r_state == ST_LOAD) ? r_row : '0;
        o_wr_data    = (r_state == ST_LOAD) ? w_pattern : '0;
    end

endmodule

// File: tb/tb_fcl_cfg_loader.sv
// Self-checking bench for fcl_cfg_loader (FIELD_W=8, FIELD_H=4); expected row writes are
// queued when a load is requested and popped as the DUT commits writes.
module tb_fcl_cfg_loader;

    localparam int FIELD_W = 8;
    localparam int FIELD_H = 4;
    localparam int ADDR_W  = 2;
    localparam int W       = ADDR_W + FIELD_W;

    logic                clk;
    logic                rst_n;
    logic                i_go;
    defs::load_cfg_req_t i_cfg_req;
    logic                o_is_loading;
    logic                o_wr_en;
    logic [ADDR_W-1:0]   o_wr_addr;
    logic [FIELD_W-1:0]  o_wr_data;
    logic                tb_rdy;

    logic [W-1:0] exp_q[$];
    int           n_chk;
    int           n_err;

    fcl_cfg_loader #(
        .FIELD_W(FIELD_W),
        .FIELD_H(FIELD_H)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_go        (i_go),
        .i_cfg_req   (i_cfg_req),
        .o_is_loading(o_is_loading),
        .o_wr_en     (o_wr_en),
        .o_wr_addr   (o_wr_addr),
        .o_wr_data   (o_wr_data)
`ifdef FCL_LOADER_WR_READY_EN
        ,
        .i_wr_ready  (tb_rdy)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Independent glider table for CFG_1
    function automatic logic [FIELD_W-1:0] glider_row(input int r);
        logic [FIELD_W-1:0] rows [0:3];
        rows[0] = 8'h02;
        rows[1] = 8'h04;
        rows[2] = 8'h07;
        rows[3] = 8'h00;
        return rows[r];
    endfunction

    task automatic push_burst();
        for (int r = 0; r < FIELD_H; r++)
            exp_q.push_back({ADDR_W'(r), glider_row(r)});
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, o_is_loading, 0);
        check({tag, "_wen"},  o_wr_en, 0);
        check({tag, "_addr"}, o_wr_addr, 0);
        check({tag, "_data"}, o_wr_data, 0);
    endtask

    // scoreboard: compare every committed write against the queue head
    always @(negedge clk) begin
        if (rst_n && o_wr_en && tb_rdy) begin
            if (exp_q.size() == 0) begin
                check("wr_unexpected_qsize", 32'(exp_q.size()), 1);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                check("wr_addr", o_wr_addr, e[W-1:FIELD_W]);
                check("wr_data", o_wr_data, e[FIELD_W-1:0]);
            end
        end
    end

    initial begin
        n_chk     = 0;
        n_err     = 0;
        rst_n     = 1'b1;
        i_go      = 1'b0;
        i_cfg_req = defs::NO_REQ;
        tb_rdy    = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check_outputs_zero("reset");
        tick(2);
        rst_n = 1'b1;
        tick(2);

        // single go with CFG_1: 4 busy cycles then idle
        i_go = 1'b1; i_cfg_req = defs::CFG_1; push_burst();
        tick(1);
        i_go = 1'b0; i_cfg_req = defs::NO_REQ;
        for (int i = 0; i < FIELD_H; i++) begin
            check("burst_busy", o_is_loading, 1);
            check("burst_addr", o_wr_addr, i);
            tick(1);
        end
        check("burst_end_busy", o_is_loading, 0);
        check("burst_q_empty", 32'(exp_q.size()), 0);
        tick(2);

        // go with NO_REQ and with an undefined request value is ignored
        i_go = 1'b1; i_cfg_req = defs::NO_REQ;
        tick(1);
        i_cfg_req = defs::load_cfg_req_t'(2'd2);
        tick(1);
        i_go = 1'b0; i_cfg_req = defs::NO_REQ;
        for (int i = 0; i < 10; i++) begin
            check("noreq_busy", o_is_loading, 0);
            check("noreq_wen", o_wr_en, 0);
            tick(1);
        end

        // go pulses during the burst (rows 1 and 3) change nothing
        i_go = 1'b1; i_cfg_req = defs::CFG_1; push_burst();
        tick(1);
        i_go = 1'b0;
        tick(1);
        check("mid_go_addr1", o_wr_addr, 1);
        i_go = 1'b1; i_cfg_req = defs::NO_REQ;
        tick(1);
        i_go = 1'b0; i_cfg_req = defs::CFG_1;
        check("mid_go_addr2", o_wr_addr, 2);
        check("mid_go_data2", o_wr_data, 8'h07);
        tick(1);
        check("mid_go_addr3", o_wr_addr, 3);
        i_go = 1'b1;
        tick(1);
        i_go = 1'b0; i_cfg_req = defs::NO_REQ;
        for (int i = 0; i < 4; i++) begin
            check("mid_go_idle", o_is_loading, 0);
            tick(1);
        end
        check("mid_go_q_empty", 32'(exp_q.size()), 0);

        // go+CFG_1 held through the returning edge starts a second burst
        i_go = 1'b1; i_cfg_req = defs::CFG_1; push_burst(); push_burst();
        tick(FIELD_H + 1);
        check("level_gap_busy", o_is_loading, 0);
        tick(1);
        i_go = 1'b0; i_cfg_req = defs::NO_REQ;
        check("level_restart_busy", o_is_loading, 1);
        check("level_restart_addr", o_wr_addr, 0);
        tick(FIELD_H + 1);
        check("level_q_empty", 32'(exp_q.size()), 0);

        // reset mid-burst at addr 2, then a clean restart
        i_go = 1'b1; i_cfg_req = defs::CFG_1; push_burst();
        tick(1);
        i_go = 1'b0; i_cfg_req = defs::NO_REQ;
        tick(2);
        check("pre_reset_addr", o_wr_addr, 2);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
        exp_q.delete();
        tick(1);
        rst_n = 1'b1;
        tick(1);
        check("post_reset_busy", o_is_loading, 0);
        i_go = 1'b1; i_cfg_req = defs::CFG_1; push_burst();
        tick(1);
        i_go = 1'b0; i_cfg_req = defs::NO_REQ;
        check("restart_addr0", o_wr_addr, 0);
        tick(FIELD_H + 1);
        check("restart_q_empty", 32'(exp_q.size()), 0);

`ifdef FCL_LOADER_WR_READY_EN
        // stall at addr 1 for 3 cycles: burst lasts FIELD_H+3 cycles
        i_go = 1'b1; i_cfg_req = defs::CFG_1; push_burst();
        tick(1);
        i_go = 1'b0; i_cfg_req = defs::NO_REQ;
        check("stall_addr0", o_wr_addr, 0);
        tick(1);
        tb_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("stall_hold_addr", o_wr_addr, 1);
            check("stall_hold_data", o_wr_data, 8'h04);
            check("stall_hold_busy", o_is_loading, 1);
            tick(1);
        end
        tb_rdy = 1'b1;
        check("stall_last_addr", o_wr_addr, 1);
        tick(1);
        check("stall_addr2", o_wr_addr, 2);
        tick(1);
        check("stall_addr3", o_wr_addr, 3);
        tick(1);
        check("stall_end_busy", o_is_loading, 0);
        check("stall_q_empty", 32'(exp_q.size()), 0);
`endif

        tick(3);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
